mole_round_scheduler: RTL and testbench

- Game-level controller for the whack-a-mole datapath.
- Sequences mole spawning and expiry, which the free-running timer/mole-control pair does not do. It latches the difficulty level at game start and gates the LED randomiser with a one-cycle spawn pulse.
- Counts hits and misses from debounced switch edges into a saturating score.
- Runs the per-game countdown and ends the round. Sits between rng_mole/difficulty_fsm (inputs) and MultiLedRandomiser/display (outputs).

---
 rtl/mole_game_pkg.sv | 27 ++
 rtl/ms_countdown.sv | 30 +++
 rtl/mole_round_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_mole_round_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game controller:
// FSM states, per-level mole lifetimes and the 18-bit population count.
package mole_game_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPAWN = 2'd1,
    MOLE_UP    = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam int SCORE_MAX_DEF = 999;
  localparam int LIFE_W        = 11;

  // How long a mole stays lit, in ms, indexed by the latched difficulty level.
  localparam logic [LIFE_W-1:0] MOLE_LIFE_MS [4] = '{11'd1500, 11'd1000, 11'd700, 11'd500};

  function automatic logic [4:0] popcount18(input logic [17:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 18; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ms_countdown.sv
// Loadable down counter stepped by the millisecond tick; stops at zero.
module ms_countdown #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  // Load wins over counting so a re-arm in the same cycle as a tick is not lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en && tick && (value != '0)) begin
      value <= value - ONE;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/mole_round_scheduler.sv
// Game-level controller for whack-a-mole: sequences mole spawn/expiry, keeps a
// saturating score from switch edges and runs the per-game seconds countdown.
module mole_round_scheduler
  import mole_game_pkg::*;
#(
  parameter int GAME_SECONDS = 30,
  parameter int MS_PER_SEC   = 1000,
  parameter int SCORE_MAX    = SCORE_MAX_DEF,
  parameter int DELAY_W      = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ms_tick,
  input  logic               start,
  input  logic [1:0]         level,
  input  logic [DELAY_W-1:0] spawn_delay,
  input  logic [17:0]        mole_mask,
  input  logic [17:0]        hit_edge,
  output logic               spawn,
  output logic               clear,
  output logic [9:0]         score,
  output logic [6:0]         time_left,
  output logic [1:0]         level_q,
  output logic [1:0]         state_q,
  output logic               game_over
);

  localparam int SEC_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(MS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   SEC_ONE    = SEC_W'(1);
  localparam logic [6:0]         GAME_TIME  = 7'(GAME_SECONDS);
  localparam logic signed [11:0] SCORE_CEIL = 12'(SCORE_MAX);
  localparam logic [9:0]         SCORE_TOP  = 10'(SCORE_MAX);

  state_t             state, state_next;
  logic [SEC_W-1:0]   sec_cnt, sec_next;
  logic [9:0]         score_next, score_sat;
  logic [6:0]         time_next;
  logic [1:0]         level_next;
  logic               spawn_next, clear_next;
  logic               wait_load, wait_en, wait_zero;
  logic               life_load, life_en, life_zero;
  logic [DELAY_W-1:0] wait_cnt;
  logic [LIFE_W-1:0]  life_cnt, life_init;
  logic [4:0]         hits, misses, all_edges, add_pts, sub_pts;
  logic signed [11:0] score_sum;
  logic               cnt_unused;

  assign wait_en   = (state == WAIT_SPAWN);
  assign life_en   = (state == MOLE_UP);
  assign life_init = MOLE_LIFE_MS[level_q];

  ms_countdown #(.W(DELAY_W)) u_wait_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (wait_load),
    .load_value (spawn_delay),
    .en         (wait_en),
    .tick       (ms_tick),
    .value      (wait_cnt),
    .zero       (wait_zero)
  );

  ms_countdown #(.W(LIFE_W)) u_life_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (life_load),
    .load_value (life_init),
    .en         (life_en),
    .tick       (ms_tick),
    .value      (life_cnt),
    .zero       (life_zero)
  );

  // The controller only ever looks at the counters through their zero flags.
  assign cnt_unused = ^{wait_cnt, life_cnt};

  // Every edge while no mole is up is a miss; while a mole is up, lit edges score.
  always_comb begin
    hits      = popcount18(hit_edge & mole_mask);
    misses    = popcount18(hit_edge & ~mole_mask);
    all_edges = popcount18(hit_edge);
    add_pts   = 5'd0;
    sub_pts   = 5'd0;
    if (state == MOLE_UP) begin
      add_pts = hits;
      sub_pts = misses;
    end else if (state == WAIT_SPAWN) begin
      sub_pts = all_edges;
    end
    score_sum = $signed({2'b00, score}) + $signed({7'd0, add_pts}) - $signed({7'd0, sub_pts});
    if (score_sum < 12'sd0) begin
      score_sat = '0;
    end else if (score_sum > SCORE_CEIL) begin
      score_sat = SCORE_TOP;
    end else begin
      score_sat = score_sum[9:0];
    end
  end

  always_comb begin
    state_next = state;
    sec_next   = sec_cnt;
    score_next = score;
    time_next  = time_left;
    level_next = level_q;
    spawn_next = 1'b0;
    clear_next = 1'b0;
    wait_load  = 1'b0;
    life_load  = 1'b0;

    case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_next = WAIT_SPAWN;
          score_next = '0;
          time_next  = GAME_TIME;
          sec_next   = '0;
          level_next = level;
          wait_load  = 1'b1;
        end
      end

      WAIT_SPAWN, MOLE_UP: begin
        score_next = score_sat;
        if (state == WAIT_SPAWN) begin
          if (wait_zero) begin
            spawn_next = 1'b1;
            life_load  = 1'b1;
            state_next = MOLE_UP;
          end
        end else if ((hits != 5'd0) || life_zero) begin
          clear_next = 1'b1;
          wait_load  = 1'b1;
          state_next = WAIT_SPAWN;
        end

        // End of game overrides any spawn or mole retirement decided above.
        if (ms_tick) begin
          if (sec_cnt == SEC_LAST) begin
            sec_next = '0;
            if (time_left <= 7'd1) begin
              time_next  = 7'd0;
              clear_next = 1'b1;
              spawn_next = 1'b0;
              wait_load  = 1'b0;
              life_load  = 1'b0;
              state_next = GAME_OVER;
            end else begin
              time_next = time_left - 7'd1;
            end
          end else begin
            sec_next = sec_cnt + SEC_ONE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      sec_cnt   <= '0;
      score     <= '0;
      time_left <= '0;
      level_q   <= '0;
      spawn     <= 1'b0;
      clear     <= 1'b0;
    end else begin
      state     <= state_next;
      sec_cnt   <= sec_next;
      score     <= score_next;
      time_left <= time_next;
      level_q   <= level_next;
      spawn     <= spawn_next;
      clear     <= clear_next;
    end
  end

  assign state_q   = state;
  assign game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Self-checking bench for mole_round_scheduler: scoreboarded clear events,
// a table of hit/miss vectors and hand-written timing sequences.
module tb_mole_round_scheduler;

  localparam int GS = 2;
  localparam int MS = 1000;
  localparam int DW = 11;
  localparam logic [17:0] ALL = 18'h3FFFF;

  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_UP   = 2;
  localparam int ST_OVER = 3;

  logic          clk = 1'b0;
  logic          reset_n, ms_tick, start;
  logic [1:0]    level;
  logic [DW-1:0] spawn_delay;
  logic [17:0]   mole_mask, hit_edge;
  logic          spawn, clear, game_over;
  logic [9:0]    score;
  logic [6:0]    time_left;
  logic [1:0]    level_q, state_q;

  mole_round_scheduler #(
    .GAME_SECONDS (GS),
    .MS_PER_SEC   (MS),
    .SCORE_MAX    (999),
    .DELAY_W      (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ms_tick     (ms_tick),
    .start       (start),
    .level       (level),
    .spawn_delay (spawn_delay),
    .mole_mask   (mole_mask),
    .hit_edge    (hit_edge),
    .spawn       (spawn),
    .clear       (clear),
    .score       (score),
    .time_left   (time_left),
    .level_q     (level_q),
    .state_q     (state_q),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int state;
  } exp_t;

  typedef struct {
    logic [17:0] mask;
    logic [17:0] hit;
    int          exp_score;
    bit          exp_clear;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tick_total = 0;
  int   model_score;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ms_tick = 1'b1;
    cycle();
    ms_tick = 1'b0;
    tick_total++;
  endtask

  task automatic waitState(input int target, input string name);
    int n;
    n = 0;
    while ((int'(state_q) != target) && (n < 50)) begin
      cycle();
      n++;
    end
    checkOutput(name, int'(state_q), target);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " state"}, int'(state_q), ST_IDLE);
    checkOutput({tag, " score"}, int'(score), 0);
    checkOutput({tag, " time_left"}, int'(time_left), 0);
    checkOutput({tag, " level_q"}, int'(level_q), 0);
    checkOutput({tag, " spawn"}, int'(spawn), 0);
    checkOutput({tag, " clear"}, int'(clear), 0);
    checkOutput({tag, " game_over"}, int'(game_over), 0);
  endtask

  // Waits for a lit mole, presents one cycle of switch edges and checks the result.
  task automatic applyStimulus(input logic [17:0] mask, input logic [17:0] hit,
                               input int exp_score, input bit exp_clear, input string name);
    exp_t e;
    waitState(ST_UP, {name, " mole up"});
    mole_mask = mask;
    hit_edge  = hit;
    if (exp_clear) begin
      e.score = exp_score;
      e.state = ST_WAIT;
      sb.push_back(e);
    end
    cycle();
    hit_edge = '0;
    checkOutput({name, " score"}, int'(score), exp_score);
    checkOutput({name, " state"}, int'(state_q), exp_clear ? ST_WAIT : ST_UP);
    if (exp_clear) checkOutput({name, " clear"}, int'(clear), 1);
  endtask

  // Every clear pulse must match the next expected event.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (clear) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected clear", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb clear score", int'(score), e.score);
        checkOutput("sb clear state", int'(state_q), e.state);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t        e;
    logic [17:0] part;
    int          rem;

    vecs[0] = '{18'h00011, 18'h00013, 1,  1'b1};
    vecs[1] = '{18'h00001, 18'h00002, 0,  1'b0};
    vecs[2] = '{18'h00001, 18'h00002, 0,  1'b0};
    vecs[3] = '{ALL,       ALL,       18, 1'b1};
    vecs[4] = '{18'h0000F, 18'h000F0, 14, 1'b0};
    vecs[5] = '{18'h0000F, 18'h000FF, 14, 1'b1};

    reset_n = 1'b0; ms_tick = 1'b0; start = 1'b0; level = 2'd0;
    spawn_delay = '0; mole_mask = '0; hit_edge = '0;
    cycle();
    cycle();
    checkReset("reset");
    reset_n = 1'b1;
    cycle();

    $display("[TB] start at level 2, spawn delay 5");
    level = 2'd2; spawn_delay = 11'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    checkOutput("start state", int'(state_q), ST_WAIT);
    checkOutput("start time_left", int'(time_left), GS);
    checkOutput("start level_q", int'(level_q), 2);
    checkOutput("start score", int'(score), 0);
    repeat (5) begin
      tick();
      checkOutput("no early spawn", int'(spawn), 0);
    end
    cycle();
    checkOutput("spawn after delay", int'(spawn), 1);
    checkOutput("state after spawn", int'(state_q), ST_UP);
    cycle();
    checkOutput("spawn one cycle", int'(spawn), 0);

    $display("[TB] level-2 mole life expiry");
    mole_mask = 18'h00010; spawn_delay = '0;
    repeat (700) tick();
    checkOutput("mole still up", int'(state_q), ST_UP);
    checkOutput("no clear before life end", int'(clear), 0);
    e.score = 0; e.state = ST_WAIT;
    sb.push_back(e);
    cycle();
    checkOutput("life expiry clear", int'(clear), 1);
    checkOutput("time_left mid game", int'(time_left), GS);

    $display("[TB] hit/miss vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].mask, vecs[i].hit, vecs[i].exp_score, vecs[i].exp_clear,
                    $sformatf("vec%0d", i));
    end

    $display("[TB] edges while waiting count as misses");
    spawn_delay = 11'd3;
    applyStimulus(ALL, ALL, 32, 1'b1, "arm delay");
    hit_edge = 18'h00005;
    cycle();
    hit_edge = '0;
    checkOutput("wait miss score", int'(score), 30);
    checkOutput("wait miss state", int'(state_q), ST_WAIT);
    spawn_delay = '0;
    repeat (3) tick();
    waitState(ST_UP, "respawn after delay");

    $display("[TB] climb to saturation");
    model_score = 30;
    while (model_score + 18 <= 998) begin
      model_score += 18;
      applyStimulus(ALL, ALL, model_score, 1'b1, "climb");
    end
    rem = 998 - model_score;
    if (rem > 0) begin
      part = (18'd1 << rem) - 18'd1;
      applyStimulus(ALL, part, 998, 1'b1, "to 998");
    end
    applyStimulus(18'h00007, 18'h00007, 999, 1'b1, "saturate 999");
    applyStimulus(18'h00007, 18'h0000F, 999, 1'b1, "net add at max");
    applyStimulus(ALL, ALL, 999, 1'b1, "hold at max");

    $display("[TB] start and level change ignored mid-game");
    waitState(ST_UP, "mole up before ignored start");
    level = 2'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    checkOutput("ignored start level_q", int'(level_q), 2);
    checkOutput("ignored start state", int'(state_q), ST_UP);
    checkOutput("ignored start time_left", int'(time_left), GS);
    checkOutput("ignored start score", int'(score), 999);

    $display("[TB] run the game clock out");
    spawn_delay = 11'd2047;
    e.score = 999; e.state = ST_WAIT;
    sb.push_back(e);
    e.score = 999; e.state = ST_OVER;
    sb.push_back(e);
    while (tick_total < 999) tick();
    checkOutput("time_left before 1s", int'(time_left), 2);
    tick();
    checkOutput("time_left after 1s", int'(time_left), 1);
    while (tick_total < 1999) tick();
    checkOutput("game_over before end", int'(game_over), 0);
    tick();
    checkOutput("game_over at end", int'(game_over), 1);
    checkOutput("end state", int'(state_q), ST_OVER);
    checkOutput("end time_left", int'(time_left), 0);
    checkOutput("end clear", int'(clear), 1);
    cycle();
    checkOutput("end clear one cycle", int'(clear), 0);
    checkOutput("score held", int'(score), 999);
    checkOutput("level_q held", int'(level_q), 2);

    $display("[TB] restart from game over at level 3");
    spawn_delay = '0; start = 1'b1;
    cycle();
    start = 1'b0;
    checkOutput("restart score", int'(score), 0);
    checkOutput("restart time_left", int'(time_left), GS);
    checkOutput("restart level_q", int'(level_q), 3);
    checkOutput("restart state", int'(state_q), ST_WAIT);
    checkOutput("restart game_over", int'(game_over), 0);
    waitState(ST_UP, "restart spawn");
    repeat (500) tick();
    checkOutput("level-3 mole still up", int'(state_q), ST_UP);
    checkOutput("level-3 no clear yet", int'(clear), 0);
    e.score = 0; e.state = ST_WAIT;
    sb.push_back(e);
    cycle();
    checkOutput("level-3 life clear", int'(clear), 1);

    $display("[TB] reset during a lit mole");
    waitState(ST_UP, "mole up before reset");
    reset_n = 1'b0;
    cycle();
    checkReset("mid-game reset");
    reset_n = 1'b1;
    cycle();
    checkOutput("idle after reset", int'(state_q), ST_IDLE);

    cycle();
    checkOutput("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
